// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pkg
// Description : Shared definitions for the memory-mapped output port path.
// Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      CLK_HI = 2'd2,
      LATCH  = 2'd3
   } shift_state_t;

   localparam int unsigned IO_PORT_W    = 8;
   localparam logic [31:0] IO_PORT_ADDR = 32'd8;

endpackage
`default_nettype wire

// File: rtl/io_port_shifter.sv
`default_nettype none
// ============================================================================
// Module      : io_port_shifter
// Description : Serialises the output port onto a 74HC595-style shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_shifter
   import io_pkg::*;
#(
   parameter int unsigned DATA_W    = IO_PORT_W,
   parameter int unsigned CLK_DIV   = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] io_port,
   input  logic              refresh,
   output logic              sr_data,
   output logic              sr_clk,
   output logic              sr_latch,
   output logic              busy
);

   localparam int unsigned      DIV_W    = $clog2(CLK_DIV + 1);
   localparam int unsigned      BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   if (CLK_DIV == 0) begin : g_clk_div_check
      $error("io_port_shifter: CLK_DIV must be at least 1");
   end

   function automatic logic first_bit(input logic [DATA_W-1:0] v);
      return MSB_FIRST ? v[DATA_W-1] : v[0];
   endfunction

   function automatic logic [DATA_W-1:0] shift_once(input logic [DATA_W-1:0] v);
      return MSB_FIRST ? (v << 1) : (v >> 1);
   endfunction

   shift_state_t      state_q, state_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] last_sent_q, last_sent_d;
   logic              pend_refresh_q, pend_refresh_d;
   logic              sr_data_q, sr_data_d;
   logic              sr_clk_q, sr_clk_d;
   logic              sr_latch_q, sr_latch_d;
   logic              busy_q, busy_d;

   logic              div_last;
   logic [DATA_W-1:0] shreg_next;

   assign div_last   = (div_cnt_q == DIV_LAST);
   assign shreg_next = shift_once(shreg_q);

   always_comb begin
      state_d        = state_q;
      div_cnt_d      = div_cnt_q;
      bit_cnt_d      = bit_cnt_q;
      shreg_d        = shreg_q;
      last_sent_d    = last_sent_q;
      // A refresh that arrives mid-frame is remembered and served once on return to IDLE
      pend_refresh_d = pend_refresh_q | (refresh && (state_q != IDLE));
      sr_data_d      = sr_data_q;
      sr_clk_d       = sr_clk_q;
      sr_latch_d     = sr_latch_q;
      busy_d         = busy_q;

      case (state_q)
         IDLE: begin
            if ((io_port != last_sent_q) || refresh || pend_refresh_q) begin
               shreg_d        = io_port;
               last_sent_d    = io_port;
               pend_refresh_d = 1'b0;
               bit_cnt_d      = '0;
               div_cnt_d      = '0;
               busy_d         = 1'b1;
               sr_data_d      = first_bit(io_port);
               state_d        = SETUP;
            end
         end
         SETUP: begin
            if (div_last) begin
               div_cnt_d = '0;
               sr_clk_d  = 1'b1;
               state_d   = CLK_HI;
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         CLK_HI: begin
            if (div_last) begin
               div_cnt_d = '0;
               sr_clk_d  = 1'b0;
               if (bit_cnt_q == BIT_LAST) begin
                  sr_latch_d = 1'b1;
                  state_d    = LATCH;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shreg_d   = shreg_next;
                  sr_data_d = first_bit(shreg_next);
                  state_d   = SETUP;
               end
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         LATCH: begin
            if (div_last) begin
               div_cnt_d  = '0;
               sr_latch_d = 1'b0;
               sr_data_d  = 1'b0;
               busy_d     = 1'b0;
               state_d    = IDLE;
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         div_cnt_q      <= '0;
         bit_cnt_q      <= '0;
         shreg_q        <= '0;
         last_sent_q    <= '0;
         pend_refresh_q <= 1'b0;
         sr_data_q      <= 1'b0;
         sr_clk_q       <= 1'b0;
         sr_latch_q     <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         div_cnt_q      <= div_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         shreg_q        <= shreg_d;
         last_sent_q    <= last_sent_d;
         pend_refresh_q <= pend_refresh_d;
         sr_data_q      <= sr_data_d;
         sr_clk_q       <= sr_clk_d;
         sr_latch_q     <= sr_latch_d;
         busy_q         <= busy_d;
      end
   end

   assign sr_data  = sr_data_q;
   assign sr_clk   = sr_clk_q;
   assign sr_latch = sr_latch_q;
   assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_io_port_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_shifter
// Description : Bench for io_port_shifter; pin-level decoder against a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_shifter;

   localparam int FRAME_LEN  = (2 * 8 + 1) * 4;
   localparam int FRAME_LEN2 = (2 * 8 + 1) * 1;

   logic       clk;
   logic       reset;
   logic [7:0] io_port, io_port2;
   logic       refresh, refresh2;
   logic       sr_data, sr_clk, sr_latch, busy;
   logic       sr_data2, sr_clk2, sr_latch2, busy2;

   int total = 0;
   int bad   = 0;

   io_port_shifter #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset), .io_port(io_port), .refresh(refresh),
      .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch), .busy(busy)
   );

   io_port_shifter #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut2 (
      .clk(clk), .reset(reset), .io_port(io_port2), .refresh(refresh2),
      .sr_data(sr_data2), .sr_clk(sr_clk2), .sr_latch(sr_latch2), .busy(busy2)
   );

   always #5 clk = ~clk;

   // Pin-level decoder state for the default-parameter instance
   logic [7:0] frames[$];
   int         nbits[$];
   int         busy_lens[$];
   int         latch_lens[$];
   int         gaps[$];
   logic       bits[$];
   int         clk_rises, data_viol, latch_misplaced;
   int         busy_run, latch_run, idle_run;
   logic       p_clk, p_latch, p_busy, p_data;

   logic       bits2[$];
   int         busy2_run, busy2_len;
   logic       p_clk2, p_busy2;

   initial begin
      clk_rises = 0; data_viol = 0; latch_misplaced = 0;
      busy_run = 0; latch_run = 0; idle_run = 0;
      p_clk = 0; p_latch = 0; p_busy = 0; p_data = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            bits.delete();
            busy_run = 0; latch_run = 0; idle_run = 0;
            p_clk = 0; p_latch = 0; p_busy = 0; p_data = 0;
         end else begin
            if (sr_clk && !p_clk) begin
               bits.push_back(sr_data);
               clk_rises++;
            end
            if (sr_clk && p_clk && (sr_data !== p_data)) data_viol++;
            if (sr_latch && !p_latch) begin
               logic [7:0] v;
               v = 8'h00;
               foreach (bits[i]) v = {v[6:0], bits[i]};
               frames.push_back(v);
               nbits.push_back(bits.size());
               bits.delete();
               if (!(p_clk && !sr_clk)) latch_misplaced++;
            end
            if (sr_latch) latch_run++;
            else if (p_latch) begin
               latch_lens.push_back(latch_run);
               latch_run = 0;
            end
            if (busy && !p_busy) gaps.push_back(idle_run);
            if (busy) busy_run++;
            else if (p_busy) begin
               busy_lens.push_back(busy_run);
               busy_run = 0;
            end
            if (busy) idle_run = 0;
            else idle_run++;
            p_clk = sr_clk; p_latch = sr_latch; p_busy = busy; p_data = sr_data;
         end
      end
   end

   initial begin
      busy2_run = 0; busy2_len = 0; p_clk2 = 0; p_busy2 = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            p_clk2 = 0; p_busy2 = 0; busy2_run = 0;
         end else begin
            if (sr_clk2 && !p_clk2) bits2.push_back(sr_data2);
            if (busy2) busy2_run++;
            else if (p_busy2) begin
               busy2_len = busy2_run;
               busy2_run = 0;
            end
            p_clk2 = sr_clk2; p_busy2 = busy2;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      frames.delete(); nbits.delete(); busy_lens.delete();
      latch_lens.delete(); gaps.delete();
      clk_rises = 0; data_viol = 0; latch_misplaced = 0;
   endtask

   // Waits until busy has stayed low for several cycles, bounded by max_cyc
   task automatic wait_idle(input int max_cyc);
      int quiet;
      quiet = 0;
      for (int c = 0; c < max_cyc && quiet < 4; c++) begin
         step(1);
         if (busy) quiet = 0;
         else quiet++;
      end
      check("idle_timeout", (quiet >= 4) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      step(1);
      refresh = 1'b0;
   endtask

   initial begin
      logic [7:0] last_sent;
      logic [7:0] exp_q[$];
      logic [7:0] v, w;
      int         ones;
      logic       do_ref, do_mid, ref_mid;

      clk = 0; reset = 1; io_port = 8'h00; refresh = 0; io_port2 = 8'h00; refresh2 = 0;
      #1;
      check("reset_outputs",  {28'd0, sr_data, sr_clk, sr_latch, busy}, 32'd0);
      check("reset_outputs2", {28'd0, sr_data2, sr_clk2, sr_latch2, busy2}, 32'd0);
      step(3);
      reset = 0;

      // Idle after reset with io_port equal to the reset value of last_sent
      step(200);
      check("idle_busy_low", {31'd0, busy}, 32'd0);
      check("idle_no_sclk", clk_rises, 0);
      check("idle_no_frame", busy_lens.size() + gaps.size(), 0);

      // LSB-first, single-cycle divider instance
      io_port2 = 8'h01;
      step(30);
      ones = 0;
      for (int i = 1; i < bits2.size(); i++) ones += int'(bits2[i]);
      check("lsb_nbits", bits2.size(), 8);
      check("lsb_first_bit", {31'd0, bits2[0]}, 32'd1);
      check("lsb_rest_zero", ones, 0);
      check("lsb_busy_len", busy2_len, FRAME_LEN2);

      // 0xA5 frame with two mid-frame changes that coalesce to 0xFF
      clear_stats();
      io_port = 8'hA5;
      step(10);
      io_port = 8'h3C;
      step(10);
      io_port = 8'hFF;
      wait_idle(400);
      check("a5_nframes", frames.size(), 2);
      check("a5_frame0", frames[0], 8'hA5);
      check("a5_frame1", frames[1], 8'hFF);
      check("a5_busy0", busy_lens[0], FRAME_LEN);
      check("a5_busy1", busy_lens[1], FRAME_LEN);
      check("a5_nbits", nbits[0], 8);
      check("a5_sclk_rises", clk_rises, 16);
      check("a5_latch_len", latch_lens[0], 4);
      check("a5_latch_place", latch_misplaced, 0);
      check("a5_setup_hold", data_viol, 0);
      check("a5_gap", gaps[1], 1);

      // Two refreshes inside one frame add exactly one frame
      clear_stats();
      io_port = 8'h5A;
      step(10);
      pulse_refresh();
      step(20);
      pulse_refresh();
      wait_idle(400);
      check("ref_nframes", frames.size(), 2);
      check("ref_frame0", frames[0], 8'h5A);
      check("ref_frame1", frames[1], 8'h5A);

      // Reset 20 cycles into a frame
      clear_stats();
      io_port = 8'h11;
      step(21);
      check("rst_was_busy", {31'd0, busy}, 32'd1);
      #2 reset = 1;
      #1;
      check("rst_async_outs", {28'd0, sr_data, sr_clk, sr_latch, busy}, 32'd0);
      check("rst_no_latch", frames.size(), 0);
      io_port = 8'h5A;
      step(3);
      check("rst_held_outs", {28'd0, sr_data, sr_clk, sr_latch, busy}, 32'd0);
      clear_stats();
      reset = 0;
      wait_idle(400);
      check("rst_nframes", frames.size(), 1);
      check("rst_frame", frames[0], 8'h5A);
      check("rst_busy", busy_lens[0], FRAME_LEN);
      last_sent = 8'h5A;

      // Randomised traffic against the frame model
      for (int it = 0; it < 12; it++) begin
         clear_stats();
         exp_q.delete();
         v = ($urandom_range(0, 3) == 0) ? last_sent : 8'($urandom_range(0, 255));
         do_ref = ($urandom_range(0, 2) == 0);
         io_port = v;
         refresh = do_ref;
         step(1);
         refresh = 1'b0;
         if ((v != last_sent) || do_ref) begin
            exp_q.push_back(v);
            last_sent = v;
            do_mid = ($urandom_range(0, 1) == 1);
            if (do_mid) begin
               step($urandom_range(5, 40));
               w = ($urandom_range(0, 2) == 0) ? v : 8'($urandom_range(0, 255));
               ref_mid = ($urandom_range(0, 2) == 0);
               io_port = w;
               if (ref_mid) pulse_refresh();
               if ((w != last_sent) || ref_mid) begin
                  exp_q.push_back(w);
                  last_sent = w;
               end
            end
         end
         wait_idle(400);
         check("rnd_nframes", frames.size(), exp_q.size());
         foreach (exp_q[i]) begin
            check("rnd_frame", frames[i], exp_q[i]);
            check("rnd_busy", busy_lens[i], FRAME_LEN);
         end
         check("rnd_setup_hold", data_viol, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
